seg7_hex_reader: RTL and testbench

//  Decodes the four active-low 7-segment digit buses HEX3..HEX0 back into a 16-bit hex value.
//  It is the reading end of the operand/result display path, used as an on-chip monitor and as a bench checker.

---
 rtl/seg7_hex_reader_if.sv | 31 +++
 rtl/seg7_hex_reader.sv | 162 ++++++++++++++++
 tb/tb_seg7_hex_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_hex_reader_if.sv
// Output side of seg7_hex_reader: decoded value plus valid/ready handshake.
// Latency: none (wires only).
// Backpressure: the slave holds off with out_ready=0; the master holds value/digit_err steady meanwhile.
//  out_valid  master->slave  reported sample present
//  out_ready  slave->master  consumer takes the sample on a valid&&ready edge
//  value      master->slave  16-bit decoded {HEX3,HEX2,HEX1,HEX0}
//  digit_err  master->slave  per-digit flag: segment pattern was not a hex glyph
//  deferred   master->slave  sticky flag: a capture was held off by a pending output
interface seg7_hex_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        deferred;

    modport master (
        output out_valid,
        output value,
        output digit_err,
        output deferred,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  value,
        input  digit_err,
        input  deferred,
        output out_ready
    );
endinterface

// File: rtl/seg7_hex_reader.sv
// Reads four active-low 7-segment digits back into a 16-bit value, debounced by a stability counter.
// Latency: a new vector is presented STABLE_CYCLES+1 rising edges after it first appears.
// Backpressure: while a report is pending and unaccepted, new stable vectors are not captured (deferred flag set).
//  CLOCK_50   in  system clock, rising edge
//  rst_n      in  asynchronous active-low reset
//  HEX0..HEX3 in  digit segments {g,f,e,d,c,b,a}, active-low, HEX0 = LS nibble
//  out_if     master modport: out_valid/out_ready handshake, value, digit_err, deferred
module seg7_hex_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [6:0]        HEX0,
    input  logic [6:0]        HEX1,
    input  logic [6:0]        HEX2,
    input  logic [6:0]        HEX3,
    seg7_hex_reader_if.master out_if
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        TRACK   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [27:0]      hex_vec;
    logic [27:0]      seg_q;
    logic [27:0]      last_rep;
    logic             last_ok;
    logic [CNT_W-1:0] cnt;
    logic             same;
    logic             stable;
    logic             new_vec;
    logic             capture;
    logic             set_def;
    logic [15:0]      dec_value;
    logic [3:0]       dec_err;
    logic [4:0]       dig_dec;
    logic [15:0]      value_q;
    logic [3:0]       err_q;
    logic             def_q;

    // Returns {err, nibble}; only exact glyph matches decode, everything else (blank included) is an error reading 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: seg_decode = 5'h00;
            7'b1111001: seg_decode = 5'h01;
            7'b0100100: seg_decode = 5'h02;
            7'b0110000: seg_decode = 5'h03;
            7'b0011001: seg_decode = 5'h04;
            7'b0010010: seg_decode = 5'h05;
            7'b0000010: seg_decode = 5'h06;
            7'b1111000: seg_decode = 5'h07;
            7'b0000000: seg_decode = 5'h08;
            7'b0010000: seg_decode = 5'h09;
            7'b0001000: seg_decode = 5'h0A;
            7'b0000011: seg_decode = 5'h0B;
            7'b1000110: seg_decode = 5'h0C;
            7'b0100001: seg_decode = 5'h0D;
            7'b0000110: seg_decode = 5'h0E;
            7'b0001110: seg_decode = 5'h0F;
            default:    seg_decode = 5'h10;
        endcase
    endfunction

    assign hex_vec = {HEX3, HEX2, HEX1, HEX0};

    always_comb begin
        dec_value = '0;
        dec_err   = '0;
        dig_dec   = '0;
        for (int i = 0; i < 4; i++) begin
            dig_dec              = seg_decode(hex_vec[7*i +: 7]);
            dec_value[4*i +: 4]  = dig_dec[3:0];
            dec_err[i]           = dig_dec[4];
        end
    end

    // The current input is compared against last edge's sample; cnt counts how many edges in a row it matched.
    assign same    = (hex_vec == seg_q);
    assign stable  = same && (cnt >= CNT_THR);
    assign new_vec = stable && (!last_ok || (hex_vec != last_rep));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '1;
            cnt   <= '0;
        end else begin
            seg_q <= hex_vec;
            if (!same) begin
                cnt <= '0;
            end else if (cnt < CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= TRACK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        set_def   = 1'b0;
        case (state)
            TRACK: begin
                if (new_vec) begin
                    capture   = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (out_if.out_ready) begin
                    // Acceptance frees the output slot this same edge, so a waiting vector moves straight in.
                    if (new_vec) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = TRACK;
                    end
                end else if (new_vec) begin
                    set_def = 1'b1;
                end
            end
            default: state_nxt = TRACK;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            err_q    <= '0;
            last_rep <= '1;
            last_ok  <= 1'b0;
            def_q    <= 1'b0;
        end else begin
            if (capture) begin
                value_q  <= dec_value;
                err_q    <= dec_err;
                last_rep <= hex_vec;
                last_ok  <= 1'b1;
            end
            if (set_def) begin
                def_q <= 1'b1;
            end
        end
    end

    assign out_if.out_valid = (state == PRESENT);
    assign out_if.value     = value_q;
    assign out_if.digit_err = err_q;
    assign out_if.deferred  = def_q;

endmodule

// File: tb/tb_seg7_hex_reader.sv
// Bench for seg7_hex_reader: directed scenarios then randomized vectors, checked against a reference model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: out_ready driven from the stimulus, randomly in the random phase.
module tb_seg7_hex_reader;

    localparam int S = 4;

    // Glyph table indexed by hex digit, {g,f,e,d,c,b,a} active-low.
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       CLOCK_50;
    logic       rst_n;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    seg7_hex_reader_if bus ();

    seg7_hex_reader #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .out_if   (bus.master)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec;
    int n_bad;

    // Reference model: how long the current vector has been seen, and a one-slot output buffer.
    logic [27:0] m_last;
    int          m_age;
    logic        m_valid;
    logic [15:0] m_value;
    logic [3:0]  m_err;
    logic        m_def;
    logic        m_have_rep;
    logic [27:0] m_rep;

    function automatic logic [27:0] mk(input int d3, input int d2, input int d1, input int d0);
        return {SEG[d3], SEG[d2], SEG[d1], SEG[d0]};
    endfunction

    function automatic logic [27:0] word(input logic [15:0] w);
        return mk(int'(w[15:12]), int'(w[11:8]), int'(w[7:4]), int'(w[3:0]));
    endfunction

    task automatic model_reset();
        m_last     = '1;
        m_age      = 1;
        m_valid    = 1'b0;
        m_value    = '0;
        m_err      = '0;
        m_def      = 1'b0;
        m_have_rep = 1'b0;
        m_rep      = '0;
    endtask

    task automatic model_present(input logic [27:0] h);
        m_valid    = 1'b1;
        m_value    = '0;
        m_err      = '0;
        for (int d = 0; d < 4; d++) begin
            logic [6:0] pat;
            logic       hit;
            pat = h[7*d +: 7];
            hit = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (SEG[k] == pat) begin
                    m_value[4*d +: 4] = 4'(k);
                    hit = 1'b1;
                end
            end
            m_err[d] = !hit;
        end
        m_have_rep = 1'b1;
        m_rep      = h;
    endtask

    task automatic model_edge(input logic [27:0] h, input logic rdy);
        logic fresh;
        if (h == m_last) begin
            if (m_age < 100000) m_age++;
        end else begin
            m_age = 1;
        end
        m_last = h;
        // A vector is stable once it has been sampled on S+1 consecutive edges (reset's all-ones counts as one).
        fresh = (m_age >= S + 1) && (!m_have_rep || h != m_rep);
        if (!m_valid || rdy) begin
            if (fresh) model_present(h);
            else       m_valid = 1'b0;
        end else if (fresh) begin
            m_def = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"},    32'(bus.out_valid), 32'(m_valid));
        chk({tag, "_value"},    32'(bus.value),     32'(m_value));
        chk({tag, "_digit_err"},32'(bus.digit_err), 32'(m_err));
        chk({tag, "_deferred"}, 32'(bus.deferred),  32'(m_def));
    endtask

    task automatic step(input logic [27:0] h, input logic rdy, input string tag);
        {HEX3, HEX2, HEX1, HEX0} = h;
        bus.out_ready = rdy;
        @(posedge CLOCK_50);
        model_edge(h, rdy);
        #1;
        chk_model(tag);
    endtask

    function automatic logic [27:0] rand_vec();
        logic [27:0] v;
        for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 9) == 0) v[7*d +: 7] = 7'($urandom);
            else                           v[7*d +: 7] = SEG[$urandom_range(0, 15)];
        end
        return v;
    endfunction

    initial begin
        logic [27:0] v;
        logic [27:0] v1234;
        logic [27:0] v00ff;
        int          hold;

        n_vec = 0;
        n_bad = 0;
        v1234 = mk(1, 2, 3, 4);
        v00ff = mk(0, 0, 15, 15);

        // Reset with 0x1234 already on the digits.
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        {HEX3, HEX2, HEX1, HEX0} = v1234;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("reset_valid",    32'(bus.out_valid), 32'd0);
        chk("reset_value",    32'(bus.value),     32'd0);
        chk("reset_err",      32'(bus.digit_err), 32'd0);
        chk("reset_deferred", 32'(bus.deferred),  32'd0);
        rst_n = 1'b1;

        // T1: decode 1234, reported after edge S.
        for (int i = 0; i < 6; i++) begin
            step(v1234, 1'b0, "t1");
            if (i == S - 1) chk("t1_not_early", 32'(bus.out_valid), 32'd0);
            if (i == S) begin
                chk("t1_valid", 32'(bus.out_valid), 32'd1);
                chk("t1_value", 32'(bus.value),     32'h1234);
                chk("t1_err",   32'(bus.digit_err), 32'd0);
            end
        end
        step(v1234, 1'b1, "t1_accept");

        // T2: glitch on HEX0 restarts the count; exactly one report of 00FF.
        step(v00ff, 1'b1, "t2_hold");
        step(v00ff, 1'b1, "t2_hold");
        v = v00ff;
        v[6:0] = SEG[8];
        step(v, 1'b1, "t2_glitch");
        for (int i = 0; i < 10; i++) begin
            step(v00ff, 1'b1, "t2_restore");
            if (i < S) chk("t2_no_early", 32'(bus.out_valid), 32'd0);
            if (i == S) chk("t2_value", 32'(bus.value), 32'h00FF);
            if (i > S) chk("t2_once", 32'(bus.out_valid), 32'd0);
        end

        // T3: second vector arrives while the first is pending.
        for (int i = 0; i < 6; i++) step(word(16'hABCD), 1'b0, "t3_abcd");
        for (int i = 0; i < 6; i++) step(word(16'h0001), 1'b0, "t3_0001");
        chk("t3_held",     32'(bus.value),    32'hABCD);
        chk("t3_deferred", 32'(bus.deferred), 32'd1);
        step(word(16'h0001), 1'b1, "t3_accept");
        chk("t3_next",       32'(bus.value),     32'h0001);
        chk("t3_next_valid", 32'(bus.out_valid), 32'd1);
        step(word(16'h0001), 1'b1, "t3_accept2");

        // T4: blank digit 2 is an error reading 0.
        v = mk(0, 0, 0, 0);
        v[20:14] = BLANK;
        for (int i = 0; i < 6; i++) step(v, 1'b0, "t4");
        chk("t4_value", 32'(bus.value),     32'h0000);
        chk("t4_err",   32'(bus.digit_err), 32'h4);
        chk("t4_valid", 32'(bus.out_valid), 32'd1);
        step(v, 1'b1, "t4_accept");

        // T5: an accepted vector is never re-reported, even after a glitch and return.
        for (int i = 0; i < 6; i++) step(word(16'h5555), 1'b1, "t5_first");
        for (int i = 0; i < 20; i++) begin
            step(word(16'h5555), 1'b1, "t5_hold");
            chk("t5_norepeat", 32'(bus.out_valid), 32'd0);
        end
        step(word(16'h5558), 1'b1, "t5_glitch");
        for (int i = 0; i < 10; i++) begin
            step(word(16'h5555), 1'b1, "t5_return");
            chk("t5_return_norepeat", 32'(bus.out_valid), 32'd0);
        end

        // T6: reset while presenting 1234, then re-report after release.
        for (int i = 0; i < 6; i++) step(v1234, 1'b0, "t6_pre");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_value", 32'(bus.value),     32'd0);
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i <= S; i++) begin
            step(v1234, 1'b0, "t6_post");
            if (i == S - 1) chk("t6_not_early", 32'(bus.out_valid), 32'd0);
        end
        chk("t6_rereport", 32'(bus.value), 32'h1234);
        chk("t6_valid",    32'(bus.out_valid), 32'd1);

        // Random phase: random glyphs/garbage, random hold times, random back-pressure.
        v = v1234;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) v = rand_vec();
            hold = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++) begin
                step(v, 1'($urandom_range(0, 1)), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
